// File: rtl/poly_tone_gen.sv
`default_nettype none
//==============================================================================
// Module   : poly_tone_gen
// Brief    : Multi-channel square-wave tone generator; note changes are applied
//            only on half-period boundaries so a running tone never glitches.
// Revision : 1.0 - initial release
//==============================================================================
module poly_tone_gen #(
    parameter int NUM_CH  = 2,
    parameter int NUM_OCT = 5,
    parameter int CNT_W   = 21,
    parameter int SCALE_W = 6,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W  = $clog2(NUM_CH + 1)
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic [CH_W-1:0]    note_ch,
    input  logic [SCALE_W-1:0] note_scale,
    input  logic               note_hl,
    input  logic               note_on,
    output logic [NUM_CH-1:0]  tone,
    output logic [NUM_CH-1:0]  active,
    output logic [MIX_W-1:0]   mix
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam int unsigned   c_num_scales = 12 * NUM_OCT;
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    // Full-period counts of the base octave (C2..B2); higher octaves are shifts.
    function automatic logic [CNT_W-1:0] f_half(input logic [SCALE_W-1:0] scale,
                                                input logic               hl);
        logic [CNT_W-1:0] base;
        logic [CNT_W-1:0] half;
        int unsigned      semi;
        int unsigned      oct;
        semi = 32'(scale) % 32'd12;
        oct  = 32'(scale) / 32'd12;
        case (semi)
            32'd0:   base = CNT_W'(1528818);
            32'd1:   base = CNT_W'(1443002);
            32'd2:   base = CNT_W'(1362026);
            32'd3:   base = CNT_W'(1285678);
            32'd4:   base = CNT_W'(1213444);
            32'd5:   base = CNT_W'(1145344);
            32'd6:   base = CNT_W'(1081082);
            32'd7:   base = CNT_W'(1020408);
            32'd8:   base = CNT_W'(963112);
            32'd9:   base = CNT_W'(909090);
            32'd10:  base = CNT_W'(858074);
            default: base = CNT_W'(809912);
        endcase
        half = (base >> oct) >> 1;
        if (hl) begin
            half = half >> 1;
        end
        if (half == '0) begin
            half = c_one;
        end
        return half;
    endfunction

    logic               w_xfer;
    logic               w_pend_sel;
    logic               w_cmd_on;
    logic [CNT_W-1:0]   w_cmd_half;
    logic [NUM_CH-1:0]  w_pending;
    logic [MIX_W-1:0]   w_pop;
    logic [MIX_W-1:0]   r_mix;

    // Out-of-range channel indices see no pending bit and are simply ignored.
    always_comb begin
        w_pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (note_ch == CH_W'(i)) begin
                w_pend_sel = w_pending[i];
            end
        end
    end

    assign note_ready = reset_ & ~w_pend_sel;
    assign w_xfer     = note_valid & note_ready;
    assign w_cmd_half = f_half(note_scale, note_hl);
    assign w_cmd_on   = note_on & (32'(note_scale) < c_num_scales);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [CNT_W-1:0] r_half;
            logic [CNT_W-1:0] w_half_nxt;
            logic [CNT_W-1:0] r_hold_half;
            logic [CNT_W-1:0] w_hold_half_nxt;
            logic             r_hold_on;
            logic             w_hold_on_nxt;
            logic             r_pend;
            logic             w_pend_nxt;
            logic             r_tone;
            logic             w_tone_nxt;
            logic             r_act;
            logic             w_act_nxt;
            logic             w_sel;

            assign w_sel = w_xfer & (note_ch == CH_W'(i));

            always_comb begin
                w_state_nxt     = r_state;
                w_cnt_nxt       = r_cnt;
                w_half_nxt      = r_half;
                w_hold_half_nxt = r_hold_half;
                w_hold_on_nxt   = r_hold_on;
                w_pend_nxt      = r_pend;
                w_tone_nxt      = r_tone;
                w_act_nxt       = r_act;
                case (r_state)
                    ST_IDLE: begin
                        if (w_sel && w_cmd_on) begin
                            w_half_nxt  = w_cmd_half;
                            w_cnt_nxt   = '0;
                            w_tone_nxt  = 1'b0;
                            w_act_nxt   = 1'b1;
                            w_state_nxt = ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (r_cnt == r_half - c_one) begin
                            w_cnt_nxt  = '0;
                            w_tone_nxt = ~r_tone;
                            if (r_pend) begin
                                w_pend_nxt = 1'b0;
                                if (r_hold_on) begin
                                    w_half_nxt = r_hold_half;
                                end else begin
                                    w_tone_nxt  = 1'b0;
                                    w_act_nxt   = 1'b0;
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_one;
                        end
                        // A transfer only happens with pending clear, so a
                        // same-edge boundary above never sees this command.
                        if (w_sel) begin
                            w_pend_nxt      = 1'b1;
                            w_hold_half_nxt = w_cmd_half;
                            w_hold_on_nxt   = w_cmd_on;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset_) begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_half      <= '0;
                    r_hold_half <= '0;
                    r_hold_on   <= 1'b0;
                    r_pend      <= 1'b0;
                    r_tone      <= 1'b0;
                    r_act       <= 1'b0;
                end else begin
                    r_state     <= w_state_nxt;
                    r_cnt       <= w_cnt_nxt;
                    r_half      <= w_half_nxt;
                    r_hold_half <= w_hold_half_nxt;
                    r_hold_on   <= w_hold_on_nxt;
                    r_pend      <= w_pend_nxt;
                    r_tone      <= w_tone_nxt;
                    r_act       <= w_act_nxt;
                end
            end

            assign tone[i]      = r_tone;
            assign active[i]    = r_act;
            assign w_pending[i] = r_pend;
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + MIX_W'(tone[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_pop;
        end
    end

    assign mix = r_mix;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_poly_tone_gen
// Brief    : Directed self-checking bench for poly_tone_gen.
// Revision : 1.0 - initial release
//==============================================================================
module tb_poly_tone_gen;

    localparam int NUM_CH  = 2;
    localparam int NUM_OCT = 10;
    localparam int CNT_W   = 21;
    localparam int SCALE_W = 7;

    logic               clk = 1'b0;
    logic               reset_;
    logic               note_valid;
    logic               note_ready;
    logic [0:0]         note_ch;
    logic [SCALE_W-1:0] note_scale;
    logic               note_hl;
    logic               note_on;
    logic [1:0]         tone;
    logic [1:0]         active;
    logic [1:0]         mix;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_last = 0;

    // Octave-9 half periods: BASE[i] >> 10.
    int exp_oct9 [12] = '{1492, 1409, 1330, 1255, 1185, 1118, 1055, 996, 940, 887, 837, 790};

    poly_tone_gen #(
        .NUM_CH  (NUM_CH),
        .NUM_OCT (NUM_OCT),
        .CNT_W   (CNT_W),
        .SCALE_W (SCALE_W)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_ch    (note_ch),
        .note_scale (note_scale),
        .note_hl    (note_hl),
        .note_on    (note_on),
        .tone       (tone),
        .active     (active),
        .mix        (mix)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input int ch, input int sc, input bit hl, input bit on, output int t);
        note_valid = 1'b1;
        note_ch    = 1'(ch);
        note_scale = SCALE_W'(sc);
        note_hl    = hl;
        note_on    = on;
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_toggle(input int ch, input int budget, output int t);
        logic prev;
        prev = tone[ch];
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tone[ch] !== prev) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset_     = 1'b0;
        note_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tone !== 2'b00) begin errors++; $display("FAIL reset_tone: got %b expected 00", tone); end
        checks++; if (active !== 2'b00) begin errors++; $display("FAIL reset_active: got %b expected 00", active); end
        checks++; if (mix !== 2'd0) begin errors++; $display("FAIL reset_mix: got %0d expected 0", mix); end
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", note_ready); end
        reset_ = 1'b1;
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", note_ready); end
    endtask

    task automatic test_octave_switch();
        int t0, tx, t1, t2;
        send(0, 59, 1'b0, 1'b1, t0);
        checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL start_active: got %b expected 1", active[0]); end
        checks++; if (tone[0] !== 1'b0) begin errors++; $display("FAIL start_tone: got %b expected 0", tone[0]); end
        send(0, 59, 1'b1, 1'b1, tx);
        note_ch = 1'b0;
        #1;
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL pend_ready_ch0: got %b expected 0", note_ready); end
        note_ch = 1'b1;
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL pend_ready_ch1: got %b expected 1", note_ready); end
        note_ch = 1'b0;
        wait_toggle(0, 26000, t1);
        checks++; if (t1 - t0 !== 25309) begin errors++; $display("FAIL half_59: got %0d expected 25309", t1 - t0); end
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL ready_after_apply: got %b expected 1", note_ready); end
        wait_toggle(0, 13000, t2);
        checks++; if (t2 - t1 !== 12654) begin errors++; $display("FAIL half_59_hl: got %0d expected 12654", t2 - t1); end
        t_last = t2;
    endtask

    task automatic test_note_off();
        int t, k;
        send(0, 59, 1'b1, 1'b0, t);
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL off_pending_ready: got %b expected 0", note_ready); end
        for (k = 0; k < 13000; k++) begin
            @(negedge clk);
            if (active[0] === 1'b0) break;
        end
        checks++; if (cyc - t_last !== 12654) begin errors++; $display("FAIL off_at_boundary: got %0d expected 12654", cyc - t_last); end
        checks++; if (tone[0] !== 1'b0) begin errors++; $display("FAIL off_tone: got %b expected 0", tone[0]); end
        send(0, 120, 1'b0, 1'b1, t);
        repeat (3) @(negedge clk);
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL bad_scale_active: got %b expected 0", active[0]); end
        send(0, 5, 1'b0, 1'b0, t);
        repeat (3) @(negedge clk);
        checks++; if (active !== 2'b00) begin errors++; $display("FAIL idle_off_active: got %b expected 00", active); end
        checks++; if (tone !== 2'b00) begin errors++; $display("FAIL idle_off_tone: got %b expected 00", tone); end
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", note_ready); end
    endtask

    task automatic test_table();
        int ta, tb, ra, rb;
        for (int p = 0; p < 6; p++) begin
            do_reset(1);
            send(0, 108 + p, 1'b0, 1'b1, ta);
            send(1, 114 + p, 1'b0, 1'b1, tb);
            ra = -1;
            rb = -1;
            for (int k = 0; k < 1700; k++) begin
                @(negedge clk);
                if (ra < 0 && tone[0] === 1'b1) ra = cyc;
                if (rb < 0 && tone[1] === 1'b1) rb = cyc;
                if (ra >= 0 && rb >= 0) break;
            end
            checks++; if (ra - ta !== exp_oct9[p]) begin errors++; $display("FAIL table_%0d: got %0d expected %0d", p, ra - ta, exp_oct9[p]); end
            checks++; if (rb - tb !== exp_oct9[p + 6]) begin errors++; $display("FAIL table_%0d: got %0d expected %0d", p + 6, rb - tb, exp_oct9[p + 6]); end
        end
    endtask

    task automatic test_hl_and_mix();
        int ta, tb, ra1, ra2, rb, bad, max_mix, prev_pop;
        do_reset(1);
        send(0, 119, 1'b1, 1'b1, ta);
        send(1, 107, 1'b0, 1'b1, tb);
        ra1 = -1; ra2 = -1; rb = -1; bad = 0; max_mix = 0;
        prev_pop = int'(tone[0]) + int'(tone[1]);
        for (int k = 0; k < 2100; k++) begin
            @(negedge clk);
            if (int'(mix) != prev_pop) bad++;
            if (int'(mix) > max_mix) max_mix = int'(mix);
            prev_pop = int'(tone[0]) + int'(tone[1]);
            if (ra1 < 0 && tone[0] === 1'b1) ra1 = cyc;
            else if (ra1 >= 0 && ra2 < 0 && tone[0] === 1'b0) ra2 = cyc;
            if (rb < 0 && tone[1] === 1'b1) rb = cyc;
        end
        checks++; if (ra1 - ta !== 395) begin errors++; $display("FAIL half_119_hl: got %0d expected 395", ra1 - ta); end
        checks++; if (ra2 - ra1 !== 395) begin errors++; $display("FAIL half_119_hl_2nd: got %0d expected 395", ra2 - ra1); end
        checks++; if (rb - tb !== 1581) begin errors++; $display("FAIL half_107: got %0d expected 1581", rb - tb); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mix_track: got %0d bad cycles expected 0", bad); end
        checks++; if (max_mix !== 2) begin errors++; $display("FAIL mix_max: got %0d expected 2", max_mix); end
    endtask

    task automatic test_independent();
        int ta, tb, t, rises;
        do_reset(1);
        send(0, 119, 1'b1, 1'b1, ta);
        send(1, 24, 1'b0, 1'b1, tb);
        checks++; if (active !== 2'b11) begin errors++; $display("FAIL indep_active: got %b expected 11", active); end
        wait_toggle(0, 500, t);
        checks++; if (t - ta !== 395) begin errors++; $display("FAIL indep_ch0: got %0d expected 395", t - ta); end
        rises = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tone[1] !== 1'b0) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL indep_ch1_quiet: got %0d high cycles expected 0", rises); end
    endtask

    task automatic test_back_to_back();
        int ta, t, tx, t2, t3;
        do_reset(1);
        send(0, 119, 1'b1, 1'b1, ta);
        wait_toggle(0, 500, t);
        repeat (394) @(negedge clk);
        send(0, 107, 1'b0, 1'b1, tx);
        checks++; if (tone[0] !== 1'b0) begin errors++; $display("FAIL same_edge_toggle: got %b expected 0", tone[0]); end
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL same_edge_pending: got %b expected 0", note_ready); end
        wait_toggle(0, 500, t2);
        checks++; if (t2 - t !== 790) begin errors++; $display("FAIL same_edge_old_half: got %0d expected 790", t2 - t); end
        wait_toggle(0, 1700, t3);
        checks++; if (t3 - t2 !== 1581) begin errors++; $display("FAIL same_edge_new_half: got %0d expected 1581", t3 - t2); end
    endtask

    task automatic test_mid_reset();
        int ta, t, tx;
        do_reset(1);
        send(0, 119, 1'b1, 1'b1, ta);
        wait_toggle(0, 500, t);
        send(0, 107, 1'b0, 1'b1, tx);
        checks++; if (mix !== 2'd1) begin errors++; $display("FAIL pre_reset_mix: got %0d expected 1", mix); end
        reset_ = 1'b0;
        @(negedge clk);
        checks++; if (tone !== 2'b00) begin errors++; $display("FAIL mid_reset_tone: got %b expected 00", tone); end
        checks++; if (active !== 2'b00) begin errors++; $display("FAIL mid_reset_active: got %b expected 00", active); end
        checks++; if (mix !== 2'd0) begin errors++; $display("FAIL mid_reset_mix: got %0d expected 0", mix); end
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", note_ready); end
        reset_ = 1'b1;
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL pending_cleared: got %b expected 1", note_ready); end
        repeat (500) @(negedge clk);
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", active[0]); end
    endtask

    initial begin
        reset_     = 1'b0;
        note_valid = 1'b0;
        note_ch    = 1'b0;
        note_scale = '0;
        note_hl    = 1'b0;
        note_on    = 1'b0;
        test_reset();
        test_octave_switch();
        test_note_off();
        test_table();
        test_hl_and_mix();
        test_independent();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
